// File: rtl/mips_pkg.sv
// Shared MIPS32 pipeline constants: ISA-fixed widths, register file size and
// the zero register address.
package mips_pkg;

  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 5;
  localparam int GPR_COUNT = 32;

  localparam logic [ADDR_W-1:0] REG_ZERO  = 5'd0;
  localparam logic [DATA_W-1:0] ZERO_WORD = 32'h0000_0000;

endpackage

// File: rtl/wb_hilo.sv
// HI/LO register pair written from the writeback stage, with a same-cycle
// bypass so the ID stage sees a write in the cycle it is presented.
module wb_hilo
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              hilo_wr,
  input  logic [DATA_W-1:0] hi_wdata,
  input  logic [DATA_W-1:0] lo_wdata,
  output logic [DATA_W-1:0] hi_rdata,
  output logic [DATA_W-1:0] lo_rdata
);

  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  always_ff @(posedge clk) begin
    if (rst) begin
      hi <= ZERO_WORD;
      lo <= ZERO_WORD;
    end else if (hilo_wr) begin
      hi <= hi_wdata;
      lo <= lo_wdata;
    end
  end

  // Reads are held at zero during reset, which also suppresses the bypass.
  always_comb begin
    hi_rdata = ZERO_WORD;
    lo_rdata = ZERO_WORD;
    if (!rst) begin
      hi_rdata = hilo_wr ? hi_wdata : hi;
      lo_rdata = hilo_wr ? lo_wdata : lo;
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// Writeback-stage register file: selects the writeback value, commits it to
// the GPR array and HI/LO pair, and serves the ID stage read ports with bypass.
module wb_regfile
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] wb_mem_data,
  input  logic [DATA_W-1:0] wb_alu_result,
  input  logic [DATA_W-1:0] wb_alu_result_low,
  input  logic              wb_sel_mem,
  input  logic              wb_reg_wr,
  input  logic [ADDR_W-1:0] wb_waddr,
  input  logic              wb_hilo_wr,
  input  logic [ADDR_W-1:0] id_raddr1,
  input  logic [ADDR_W-1:0] id_raddr2,
  output logic [DATA_W-1:0] id_rdata1,
  output logic [DATA_W-1:0] id_rdata2,
  output logic [DATA_W-1:0] id_hi,
  output logic [DATA_W-1:0] id_lo,
  output logic [DATA_W-1:0] wb_commit_cnt
);

  logic [DATA_W-1:0] gpr [GPR_COUNT];
  logic [DATA_W-1:0] wb_wdata;
  logic [DATA_W-1:0] commit_cnt;
  logic              gpr_commit;

  assign wb_wdata   = wb_sel_mem ? wb_mem_data : wb_alu_result;
  assign gpr_commit = wb_reg_wr && (wb_waddr != REG_ZERO);

  // $0 is never written, so its entry stays at the reset value of zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < GPR_COUNT; i++) begin
        gpr[i] <= ZERO_WORD;
      end
      commit_cnt <= ZERO_WORD;
    end else if (gpr_commit) begin
      gpr[wb_waddr] <= wb_wdata;
      commit_cnt    <= commit_cnt + 32'd1;
    end
  end

  assign wb_commit_cnt = commit_cnt;

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] raddr);
    if (raddr == REG_ZERO)
      return ZERO_WORD;
    else if (wb_reg_wr && (wb_waddr == raddr))
      return wb_wdata;
    else
      return gpr[raddr];
  endfunction

  // Each port resolves independently; reset holds both at zero.
  always_comb begin
    id_rdata1 = ZERO_WORD;
    id_rdata2 = ZERO_WORD;
    if (!rst) begin
      id_rdata1 = read_port(id_raddr1);
      id_rdata2 = read_port(id_raddr2);
    end
  end

  wb_hilo u_hilo (
    .clk      (clk),
    .rst      (rst),
    .hilo_wr  (wb_hilo_wr),
    .hi_wdata (wb_alu_result),
    .lo_wdata (wb_alu_result_low),
    .hi_rdata (id_hi),
    .lo_rdata (id_lo)
  );

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Writeback-stage register file for the 5-stage MIPS32 pipeline: it consumes the MEM/WB pipeline register outputs and selects the writeback value (load data or ALU result). It commits that value to the 32×32 general-purpose register array and/or the HI/LO pair. It serves the ID stage's two GPR read ports and one HI/LO read port, with same-cycle write-to-read bypass so no extra forwarding path from WB is needed.

## Interface
- No parameters; widths are fixed by the ISA (32-bit data, 5-bit register address).
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- wb_mem_data  in  32  load data from MEM/WB.
- wb_alu_result  in  32  ALU result from MEM/WB; also the HI value for HI/LO writes.
- wb_alu_result_low  in  32  LO value for HI/LO writes.
- wb_sel_mem  in  1  1 = write back wb_mem_data, 0 = write back wb_alu_result.
- wb_reg_wr  in  1  GPR write enable.
- wb_waddr  in  5  GPR write address.
- wb_hilo_wr  in  1  HI/LO write enable.
- id_raddr1  in  5  read port 1 address.
- id_raddr2  in  5  read port 2 address.
- id_rdata1  out  32  read port 1 data, combinational.
- id_rdata2  out  32  read port 2 data, combinational.
- id_hi  out  32  current HI, bypassed.
- id_lo  out  32  current LO, bypassed.
- wb_commit_cnt  out  32  count of committed GPR writes, for debug and perf.

## Operation
- Writeback value: wb_wdata = wb_sel_mem ? wb_mem_data : wb_alu_result.
- GPR write: on posedge with !rst, wb_reg_wr and wb_waddr != 0, gpr[wb_waddr] <= wb_wdata.
  - Writes to $0 are dropped.
  - $0 always reads 0.
- HI/LO write: on posedge with !rst and wb_hilo_wr, hi <= wb_alu_result and lo <= wb_alu_result_low.
  - A HI/LO write and a GPR write in the same cycle both commit independently.
  - On a HI/LO-only write, wb_sel_mem is ignored.
- Read ports, evaluated per port:
  - raddr == 0 → 0.
  - Else if wb_reg_wr and wb_waddr == raddr → wb_wdata (bypass).
  - Else gpr[raddr].
  - Both ports reading the bypassed register return the same value.
- HI/LO read: id_hi = wb_hilo_wr ? wb_alu_result : hi; id_lo = wb_hilo_wr ? wb_alu_result_low : lo.
- Commit counter:
  - Increments by 1 on each posedge where a GPR write actually commits (wb_reg_wr and wb_waddr != 0).
  - Wraps 0xFFFFFFFF → 0.
  - HI/LO writes are not counted.

## Timing
- Write latency: a value presented in cycle N is stored at the posedge ending cycle N. It is visible on the read ports in cycle N via bypass and from the array from cycle N+1.
- Read latency: 0 cycles (combinational), with no handshake. The WB stage never stalls, so every asserted enable commits.
- Reset, at a posedge with rst high:
  - All 32 GPRs, hi, lo and wb_commit_cnt clear to 0.
  - Writes presented in the same cycle are discarded, and the counter does not increment.
- While rst is high:
  - id_rdata1, id_rdata2, id_hi and id_lo are forced to 0; bypass is disabled.
  - wb_commit_cnt reads 0 from the first reset edge.
- Reset mid-stream: any write in flight at the reset edge is lost. The first post-reset write lands in the cycle after rst deasserts.
- Back-to-back writes to the same register: the last one wins. Reads in each cycle return that cycle's bypassed value.

## Structure
- Shared package mips_pkg holds:
  - REG_ZERO = 5'd0.
  - The GPR count (32) and data width (32).
  - A zero word constant used for reset.
- Natural sub-module: wb_hilo, containing the hi/lo registers plus their bypass mux (~40 lines).
- The GPR array, read muxes and counter stay in wb_regfile.
- Total RTL is roughly 150 lines.

## Test plan
- Reset, then read all 32 addresses on both ports → all 0; id_hi = id_lo = 0; wb_commit_cnt = 0.
- Write $5 = 0x12345678 (sel_mem=0), with raddr1=5 in the same cycle → id_rdata1 = 0x12345678 in that cycle via bypass, still 0x12345678 next cycle from the array; cnt = 1.
- wb_sel_mem=1, wb_mem_data=0xDEADBEEF, waddr=0, raddr1=raddr2=0 → rdata = 0 in the same and next cycle; cnt unchanged.
- wb_hilo_wr with alu_result=0xAAAA0000, low=0x0000BBBB, together with a GPR write of $3 → id_hi/id_lo bypass the new values in the same cycle and hold them after; $3 is written; cnt = +1.
- Writes to $7 on three consecutive cycles (1, 2, 3), with raddr2=7 → rdata2 = 1, 2, 3 per cycle, then 3.
- Write $9 = 0x55 in the cycle rst is high → $9 still reads 0 after reset; preset cnt = 0xFFFFFFFF followed by one commit wraps to 0.
